// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI mode-0 responder emulating an 8-channel 12-bit A2D converter.
// The command in one frame selects the channel returned in the next frame.
module a2d_spi_resp #(
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 8,
    parameter int FRAME_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    input  logic [NUM_CH*DATA_W-1:0] ch_vals,
    output logic                     MISO,
    output logic [2:0]               cur_ch,
    output logic                     frm_done,
    output logic                     frm_err
);
    localparam int CW = $clog2(FRAME_W + 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic [1:0]         fresh_q, fresh_d;
    logic               arm_q, arm_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-2:0] rx_q, rx_d;
    logic [CW-1:0]      bitcnt_q, bitcnt_d;
    logic [2:0]         cur_ch_q, cur_ch_d;
    logic               done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0]  sel;
    logic               ss_fall, ss_rise, sclk_rise, sclk_fall;

    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (cur_ch_q == 3'(k)) sel = ch_vals[k*DATA_W +: DATA_W];
    end

    always_comb begin
        ss_d      = {ss_q[1:0], SS_n};
        sclk_d    = {sclk_q[1:0], SCLK};
        mosi_d    = {mosi_q[1:0], MOSI};
        fresh_d   = {fresh_q[0], 1'b1};
        // Arm only once SS_n has been seen high after reset, so a frame already open at reset is skipped
        arm_d     = arm_q | (fresh_q[1] & ss_q[1]);
        ss_fall   = arm_q & ss_q[2] & ~ss_q[1];
        ss_rise   = ~ss_q[2] & ss_q[1];
        sclk_rise = sclk_q[1] & ~sclk_q[2];
        sclk_fall = ~sclk_q[1] & sclk_q[2];
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bitcnt_d  = bitcnt_q;
        cur_ch_d  = cur_ch_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (state_q == IDLE) begin
            bitcnt_d = '0;
            if (ss_fall) begin
                state_d = SHIFT;
                tx_d    = {{(FRAME_W-DATA_W){1'b0}}, sel};
                rx_d    = '0;
            end
        end else if (ss_rise) begin
            state_d  = IDLE;
            done_d   = bitcnt_q == CW'(FRAME_W);
            err_d    = ~done_d;
            cur_ch_d = done_d ? rx_q[FRAME_W-3 -: 3] : cur_ch_q;
        end else if (sclk_rise) begin
            rx_d     = {rx_q[FRAME_W-3:0], mosi_q[2]};
            bitcnt_d = (bitcnt_q == CW'(FRAME_W + 1)) ? bitcnt_q : bitcnt_q + 1'b1;
        end else if (sclk_fall) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q     <= 3'b111;
            sclk_q   <= 3'b000;
            mosi_q   <= 3'b000;
            fresh_q  <= 2'b00;
            arm_q    <= 1'b0;
            state_q  <= IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            bitcnt_q <= '0;
            cur_ch_q <= 3'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ss_q     <= ss_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            fresh_q  <= fresh_d;
            arm_q    <= arm_d;
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            bitcnt_q <= bitcnt_d;
            cur_ch_q <= cur_ch_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign MISO     = (state_q == SHIFT) & tx_q[FRAME_W-1];
    assign cur_ch   = cur_ch_q;
    assign frm_done = done_q;
    assign frm_err  = err_q;
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed SPI-master frames against a2d_spi_resp with hand-computed responses.
module tb_a2d_spi_resp;
    localparam time H = 60;

    logic        clk = 1'b0, rst = 1'b1, SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
    logic [95:0] ch_vals;
    logic        MISO;
    logic [2:0]  cur_ch;
    logic        frm_done, frm_err;
    int          checks = 0, failures = 0, n_done = 0, n_err = 0;

    a2d_spi_resp dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .ch_vals(ch_vals), .MISO(MISO), .cur_ch(cur_ch),
        .frm_done(frm_done), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frm_done) n_done++;
        if (frm_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [15:0] cmd, input int n, input int chg_at, input int rst_at,
                         output logic [15:0] resp);
        logic [31:0] c;
        c    = {cmd, 16'h0000};
        resp = '0;
        SS_n = 1'b0;
        #(2*H);
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) ch_vals[11:0] = 12'hFFF;
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                chk("rst_mid_miso", 32'(MISO), 0);
                chk("rst_mid_cur_ch", 32'(cur_ch), 0);
                chk("rst_mid_done", 32'(frm_done), 0);
                chk("rst_mid_err", 32'(frm_err), 0);
                rst = 1'b0;
            end
            MOSI = c[31-i];
            #H;
            SCLK = 1'b1;
            if (i < 16) resp[15-i] = MISO;
            #H;
            SCLK = 1'b0;
        end
        #H;
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [15:0] cmd, input int n, input int chg_at,
                       input int rst_at, input logic chk_resp, input logic [15:0] er,
                       input int ed, input int ee, input logic [2:0] ec);
        int d0, e0;
        logic [15:0] r;
        d0 = n_done;
        e0 = n_err;
        frame(cmd, n, chg_at, rst_at, r);
        if (chk_resp) chk({tag, "_miso"}, 32'(r), 32'(er));
        chk({tag, "_done"}, n_done - d0, ed);
        chk({tag, "_err"}, n_err - e0, ee);
        chk({tag, "_cur_ch"}, 32'(cur_ch), 32'(ec));
    endtask

    initial begin
        ch_vals = {12'h707, 12'h606, 12'hC80, 12'h404, 12'h123, 12'h202, 12'h101, 12'hA5C};
        repeat (5) @(negedge clk);
        chk("rst_miso", 32'(MISO), 0);
        chk("rst_cur_ch", 32'(cur_ch), 0);
        chk("rst_done", 32'(frm_done), 0);
        chk("rst_err", 32'(frm_err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run("t1",   16'h0000, 16, -1, -1, 1'b1, 16'h0A5C, 1, 0, 3'd0);
        run("t2a",  16'h1800, 16, -1, -1, 1'b1, 16'h0A5C, 1, 0, 3'd3);
        run("t2b",  16'h0000, 16, -1, -1, 1'b1, 16'h0123, 1, 0, 3'd0);
        run("t3a",  16'h1800, 16, -1, -1, 1'b1, 16'h0A5C, 1, 0, 3'd3);
        run("t3ab", 16'h2800,  9, -1, -1, 1'b0, 16'h0000, 0, 1, 3'd3);
        run("t3b",  16'h0000, 16, -1, -1, 1'b1, 16'h0123, 1, 0, 3'd0);
        run("t4",   16'h1800, 17, -1, -1, 1'b1, 16'h0A5C, 0, 1, 3'd0);
        run("t4b",  16'h0000, 16, -1, -1, 1'b1, 16'h0A5C, 1, 0, 3'd0);
        ch_vals[11:0] = 12'h111;
        run("t5a",  16'h0000, 16,  8, -1, 1'b1, 16'h0111, 1, 0, 3'd0);
        run("t5b",  16'h0000, 16, -1, -1, 1'b1, 16'h0FFF, 1, 0, 3'd0);
        run("t6a",  16'h2800, 16, -1, -1, 1'b1, 16'h0FFF, 1, 0, 3'd5);
        run("t6r",  16'h2800, 16, -1,  8, 1'b0, 16'h0000, 0, 0, 3'd0);
        run("t6b",  16'h0000, 16, -1, -1, 1'b1, 16'h0FFF, 1, 0, 3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
